// File: rtl/axi4_hbm_traffic_gen.sv
// AXI4 HBM traffic generator: for every channel window and burst it writes a pattern
// burst, reads it back, and counts bad responses, data mismatches and misplaced rlast.
module axi4_hbm_traffic_gen #(
  parameter int          DATA_WIDTH   = 256,
  parameter int          ADDR_WIDTH   = 64,
  parameter int          ID_WIDTH     = 7,
  parameter int          NUM_CHANNELS = 2,
  parameter logic [63:0] CH_BASE      = 64'h0,
  parameter logic [63:0] CH_STRIDE    = 64'h4000_0000,
  parameter int          BURST_LEN    = 8,
  parameter int          NUM_BURSTS   = 1
) (
  input  logic                    axi_clk_in_clk,
  input  logic                    axi_reset_n_in_reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             error_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [ID_WIDTH-1:0]     awid,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [ID_WIDTH-1:0]     arid,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int WORDS = DATA_WIDTH / 32;
  localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int KW    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A      = CH_BASE[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A    = CH_STRIDE[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * BYTES);
  localparam logic [2:0]            SIZE        = 3'($clog2(BYTES));
  localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_NEXT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         ch_q;
  logic [KW-1:0]         burst_q;
  logic [7:0]            beat_q;
  logic [ADDR_WIDTH-1:0] ch_addr_q;
  logic [ADDR_WIDTH-1:0] burst_addr_q;
  logic [31:0]           pat_word;
  logic                  last_beat, last_burst, last_ch;
  logic                  err_inc;
  logic [ADDR_WIDTH-1:0] err_addr;

  assign last_beat  = (beat_q == LAST_BEAT);
  assign last_burst = (burst_q == KW'(NUM_BURSTS - 1));
  assign last_ch    = (ch_q == CW'(NUM_CHANNELS - 1));

  // Write data and read-back expectation share one generator driven by the live counters.
  assign pat_word = {8'(ch_q), 8'(burst_q), 16'(beat_q)};
  assign wdata    = {WORDS{pat_word}};
  assign wstrb    = '1;
  assign awaddr   = burst_addr_q;
  assign araddr   = burst_addr_q;
  assign awlen    = LAST_BEAT;
  assign arlen    = LAST_BEAT;
  assign awsize   = SIZE;
  assign arsize   = SIZE;
  assign awburst  = 2'b01;
  assign arburst  = 2'b01;
  assign awid     = ID_WIDTH'(ch_q);
  assign arid     = ID_WIDTH'(ch_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d  = state_q;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    bready   = 1'b0;
    arvalid  = 1'b0;
    rready   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    err_inc  = 1'b0;
    err_addr = burst_addr_q;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_AW;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_d = S_AW;
      end
      S_AW: begin
        awvalid = 1'b1;
        if (awready) state_d = S_W;
      end
      S_W: begin
        wvalid = 1'b1;
        wlast  = last_beat;
        if (wready && last_beat) state_d = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          err_inc = (bresp != 2'b00);
          state_d = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          err_inc  = (rresp != 2'b00) || (rdata != wdata) || (rlast && !last_beat);
          err_addr = burst_addr_q + (ADDR_WIDTH'(beat_q) << SIZE);
          if (last_beat) state_d = S_NEXT;
        end
      end
      S_NEXT: state_d = (last_ch && last_burst) ? S_DONE : S_AW;
      default: state_d = S_IDLE;
    endcase
  end

  assign pass = done && (error_count == 16'd0);

  always_ff @(posedge axi_clk_in_clk or negedge axi_reset_n_in_reset_n) begin
    if (!axi_reset_n_in_reset_n) begin
      state_q        <= S_IDLE;
      ch_q           <= '0;
      burst_q        <= '0;
      beat_q         <= '0;
      ch_addr_q      <= '0;
      burst_addr_q   <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          ch_q           <= '0;
          burst_q        <= '0;
          beat_q         <= '0;
          ch_addr_q      <= BASE_A;
          burst_addr_q   <= BASE_A;
          error_count    <= '0;
          first_err_addr <= '0;
        end
        S_W: if (wready) beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
        S_R: if (rvalid) beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
        S_NEXT: begin
          if (last_burst) begin
            burst_q      <= '0;
            ch_q         <= ch_q + CW'(1);
            ch_addr_q    <= ch_addr_q + STRIDE_A;
            burst_addr_q <= ch_addr_q + STRIDE_A;
          end else begin
            burst_q      <= burst_q + KW'(1);
            burst_addr_q <= burst_addr_q + BURST_BYTES;
          end
        end
        default: ;
      endcase
      if (err_inc) begin
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        if (error_count == 16'd0) first_err_addr <= err_addr;
      end
    end
  end

endmodule

// File: tb/tb_axi4_hbm_traffic_gen.sv
// Directed bench for axi4_hbm_traffic_gen: memory slave with stall/fault injection,
// plus a second, always-corrupting instance for error-counter saturation.
module tb_axi4_hbm_traffic_gen;

  logic clk, rst_n;
  logic start, busy, done, pass;
  logic [15:0] error_count;
  logic [63:0] first_err_addr, awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [6:0] awid, arid;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [255:0] wdata, rdata;
  logic [31:0] wstrb;

  logic s_start, s_busy, s_done, s_pass;
  logic [15:0] s_error_count;
  logic [63:0] s_first_err_addr, s_awaddr, s_araddr;
  logic [7:0] s_awlen, s_arlen;
  logic [2:0] s_awsize, s_arsize;
  logic [1:0] s_awburst, s_arburst, s_bresp, s_rresp;
  logic [6:0] s_awid, s_arid;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [255:0] s_wdata, s_rdata;
  logic [31:0] s_wstrb;

  int n_checks = 0;
  int n_fails = 0;

  axi4_hbm_traffic_gen #(.DATA_WIDTH(256), .ADDR_WIDTH(64), .ID_WIDTH(7), .NUM_CHANNELS(2),
    .CH_BASE(64'h0), .CH_STRIDE(64'h4000_0000), .BURST_LEN(8), .NUM_BURSTS(1)) dut (
    .axi_clk_in_clk(clk), .axi_reset_n_in_reset_n(rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .first_err_addr(first_err_addr),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready));

  axi4_hbm_traffic_gen #(.DATA_WIDTH(256), .ADDR_WIDTH(64), .ID_WIDTH(7), .NUM_CHANNELS(1),
    .CH_BASE(64'h1000), .CH_STRIDE(64'h4000_0000), .BURST_LEN(8), .NUM_BURSTS(8)) dut_sat (
    .axi_clk_in_clk(clk), .axi_reset_n_in_reset_n(rst_n), .start(s_start),
    .busy(s_busy), .done(s_done), .pass(s_pass), .error_count(s_error_count),
    .first_err_addr(s_first_err_addr),
    .awaddr(s_awaddr), .awlen(s_awlen), .awsize(s_awsize), .awburst(s_awburst), .awid(s_awid),
    .awvalid(s_awvalid), .awready(s_awready),
    .wdata(s_wdata), .wstrb(s_wstrb), .wlast(s_wlast), .wvalid(s_wvalid), .wready(s_wready),
    .bresp(s_bresp), .bvalid(s_bvalid), .bready(s_bready),
    .araddr(s_araddr), .arlen(s_arlen), .arsize(s_arsize), .arburst(s_arburst), .arid(s_arid),
    .arvalid(s_arvalid), .arready(s_arready),
    .rdata(s_rdata), .rresp(s_rresp), .rlast(s_rlast), .rvalid(s_rvalid), .rready(s_rready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: acts on the falling edge, so everything it drives is settled by the
  // next rising edge, and every valid/ready pair it sees there is the one the DUT samples.
  logic [255:0] mem [logic [63:0]];
  logic [63:0]  aw_log [$];
  logic [63:0]  ar_log [$];
  bit           stall_en, corrupt_en, bresp_err_en;
  int           stab_errs, w_errs, w_beats;
  logic [63:0]  wr_addr, rd_addr, aw_hold_addr, ar_hold_addr;
  logic [7:0]   wr_beat, rd_beat, aw_len_q, rd_len;
  logic [2:0]   aw_size_q;
  logic [1:0]   aw_burst_q;
  logic [6:0]   wr_id, rd_id;
  logic [255:0] w_hold_data;
  bit           aw_hold, w_hold, ar_hold, r_hold, r_active, b_fired, w_hold_last;

  function automatic logic rnd();
    return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
      aw_hold = 0; w_hold = 0; ar_hold = 0; r_hold = 0; r_active = 0; b_fired = 0;
    end else begin
      if (aw_hold && (!awvalid || awaddr !== aw_hold_addr)) stab_errs++;
      if (w_hold && (!wvalid || wdata !== w_hold_data || wlast !== w_hold_last)) stab_errs++;
      if (ar_hold && (!arvalid || araddr !== ar_hold_addr)) stab_errs++;

      awready = rnd();
      if (awvalid && awready) begin
        aw_log.push_back(awaddr);
        aw_len_q = awlen; aw_size_q = awsize; aw_burst_q = awburst;
        wr_id = awid; wr_addr = awaddr; wr_beat = 0;
      end
      aw_hold = awvalid && !awready; aw_hold_addr = awaddr;

      if (b_fired) begin bvalid = 0; b_fired = 0; end
      if (bvalid && bready) b_fired = 1;

      wready = rnd();
      if (wvalid && wready) begin
        mem[wr_addr + 64'(wr_beat) * 64'd32] = wdata;
        if (wlast !== (wr_beat == aw_len_q) || wstrb !== '1) w_errs++;
        w_beats++;
        wr_beat++;
        if (wlast) begin
          bvalid = 1;
          bresp = (bresp_err_en && wr_id == 7'd1) ? 2'b10 : 2'b00;
        end
      end
      w_hold = wvalid && !wready; w_hold_data = wdata; w_hold_last = wlast;

      arready = rnd();
      if (arvalid && arready) begin
        ar_log.push_back(araddr);
        rd_addr = araddr; rd_id = arid; rd_len = arlen; rd_beat = 0; r_active = 1;
      end
      ar_hold = arvalid && !arready; ar_hold_addr = araddr;

      if (r_active) begin
        if (!r_hold) rvalid = rnd();
        if (rvalid) begin
          rdata = mem[rd_addr + 64'(rd_beat) * 64'd32];
          if (corrupt_en && rd_id == 7'd0 && rd_beat == 8'd3) rdata[0] = ~rdata[0];
          rresp = 2'b00;
          rlast = (rd_beat == rd_len);
        end
        r_hold = rvalid && !rready;
        if (rvalid && rready) begin
          rd_beat++;
          if (rlast) r_active = 0;
        end
      end else begin
        rvalid = 0; rlast = 0; r_hold = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic clear_logs();
    aw_log.delete(); ar_log.delete();
    stab_errs = 0; w_errs = 0; w_beats = 0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin n_fails++; $display("FAIL reset_valids: got %b want 00000", {awvalid, wvalid, arvalid, bready, rready}); end
    n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fails++; $display("FAIL reset_status: got %b want 000", {busy, done, pass}); end
    n_checks++; if (error_count !== 16'd0 || first_err_addr !== 64'd0) begin n_fails++; $display("FAIL reset_errs: got %h/%h want 0/0", error_count, first_err_addr); end
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, done, awvalid} !== 3'b000) begin n_fails++; $display("FAIL idle_after_reset: got %b want 000", {busy, done, awvalid}); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [255:0] exp_w;
    exp_w = {8{32'h0100_0002}};
    clear_logs();
    pulse_start();
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL basic_busy: got %b want 1", busy); end
    pulse_start();
    wait_done(ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL basic_timeout: done got 0 want 1"); end
    n_checks++; if ({busy, done, pass} !== 3'b011) begin n_fails++; $display("FAIL basic_status: got %b want 011", {busy, done, pass}); end
    n_checks++; if (error_count !== 16'd0) begin n_fails++; $display("FAIL basic_errs: got %0d want 0", error_count); end
    n_checks++; if (aw_log.size() != 2) begin n_fails++; $display("FAIL basic_aw_count: got %0d want 2", aw_log.size()); end
    else if (aw_log[0] !== 64'h0 || aw_log[1] !== 64'h4000_0000) begin n_fails++; $display("FAIL basic_awaddr: got %h,%h want 0,40000000", aw_log[0], aw_log[1]); end
    n_checks++; if ({aw_len_q, aw_size_q, aw_burst_q, wr_id} !== {8'd7, 3'd5, 2'b01, 7'd1}) begin n_fails++; $display("FAIL basic_aw_fields: len %0d size %0d burst %0d id %0d want 7 5 1 1", aw_len_q, aw_size_q, aw_burst_q, wr_id); end
    n_checks++; if (ar_log.size() != 2 || rd_id !== 7'd1) begin n_fails++; $display("FAIL basic_ar: got count %0d id %0d want 2 1", ar_log.size(), rd_id); end
    else if (ar_log[1] !== 64'h4000_0000) begin n_fails++; $display("FAIL basic_araddr: got %h want 40000000", ar_log[1]); end
    n_checks++; if (mem[64'h4000_0040] !== exp_w) begin n_fails++; $display("FAIL basic_wdata: got %h want %h", mem[64'h4000_0040], exp_w); end
    n_checks++; if (w_beats != 16 || w_errs != 0) begin n_fails++; $display("FAIL basic_wbeats: got %0d beats %0d bad want 16 0", w_beats, w_errs); end
  endtask

  task automatic test_read_corrupt();
    bit ok;
    clear_logs(); corrupt_en = 1;
    pulse_start(); wait_done(ok);
    corrupt_en = 0;
    n_checks++; if (!ok) begin n_fails++; $display("FAIL corrupt_timeout: done got 0 want 1"); end
    n_checks++; if (error_count !== 16'd1 || pass !== 1'b0) begin n_fails++; $display("FAIL corrupt_count: got %0d pass %b want 1 0", error_count, pass); end
    n_checks++; if (first_err_addr !== 64'h60) begin n_fails++; $display("FAIL corrupt_addr: got %h want 60", first_err_addr); end
  endtask

  task automatic test_bresp_error();
    bit ok;
    clear_logs(); bresp_err_en = 1;
    pulse_start(); wait_done(ok);
    bresp_err_en = 0;
    n_checks++; if (!ok) begin n_fails++; $display("FAIL bresp_timeout: done got 0 want 1"); end
    n_checks++; if (error_count !== 16'd1 || pass !== 1'b0) begin n_fails++; $display("FAIL bresp_count: got %0d pass %b want 1 0", error_count, pass); end
    n_checks++; if (first_err_addr !== 64'h4000_0000) begin n_fails++; $display("FAIL bresp_addr: got %h want 40000000", first_err_addr); end
  endtask

  task automatic test_stalls();
    bit ok;
    clear_logs(); stall_en = 1;
    pulse_start(); wait_done(ok);
    stall_en = 0;
    n_checks++; if (!ok) begin n_fails++; $display("FAIL stall_timeout: done got 0 want 1"); end
    n_checks++; if (pass !== 1'b1 || error_count !== 16'd0) begin n_fails++; $display("FAIL stall_result: pass %b errs %0d want 1 0", pass, error_count); end
    n_checks++; if (stab_errs != 0) begin n_fails++; $display("FAIL stall_stability: got %0d unstable cycles want 0", stab_errs); end
    n_checks++; if (aw_log.size() != 2 || ar_log.size() != 2 || w_beats != 16 || w_errs != 0) begin n_fails++; $display("FAIL stall_traffic: aw %0d ar %0d w %0d bad %0d want 2 2 16 0", aw_log.size(), ar_log.size(), w_beats, w_errs); end
    else if (aw_log[1] !== 64'h4000_0000) begin n_fails++; $display("FAIL stall_awaddr: got %h want 40000000", aw_log[1]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ok = 0;
    clear_logs();
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (wvalid && wdata[15:0] == 16'd4) begin ok = 1; break; end
    end
    n_checks++; if (!ok) begin n_fails++; $display("FAIL midreset_reach_beat4: got no W beat 4 want beat 4"); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin n_fails++; $display("FAIL midreset_valids: got %b want 00000", {awvalid, wvalid, arvalid, bready, rready}); end
    n_checks++; if ({busy, done} !== 2'b00 || error_count !== 16'd0) begin n_fails++; $display("FAIL midreset_status: got %b errs %0d want 00 0", {busy, done}, error_count); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    pulse_start(); wait_done(ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL midreset_timeout: done got 0 want 1"); end
    n_checks++; if (pass !== 1'b1 || error_count !== 16'd0 || aw_log.size() != 2) begin n_fails++; $display("FAIL midreset_rerun: pass %b errs %0d aw %0d want 1 0 2", pass, error_count, aw_log.size()); end
  endtask

  task automatic test_saturation();
    bit ok;
    ok = 0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_error_count >= 16'd17) begin ok = 1; break; end
    end
    n_checks++; if (!ok || s_busy !== 1'b1) begin n_fails++; $display("FAIL sat_climb: reached %b busy %b want 1 1", ok, s_busy); end
    // Jump the counter near its ceiling while read beats keep failing.
    force dut_sat.error_count = 16'hFFF0;
    repeat (3) @(negedge clk);
    release dut_sat.error_count;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_done === 1'b1) begin ok = 1; break; end
    end
    n_checks++; if (!ok) begin n_fails++; $display("FAIL sat_timeout: done got 0 want 1"); end
    n_checks++; if (s_error_count !== 16'hFFFF) begin n_fails++; $display("FAIL sat_count: got %h want ffff", s_error_count); end
    n_checks++; if (s_pass !== 1'b0 || s_first_err_addr !== 64'h1000) begin n_fails++; $display("FAIL sat_first: pass %b addr %h want 0 1000", s_pass, s_first_err_addr); end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; s_start = 1'b0;
    stall_en = 0; corrupt_en = 0; bresp_err_en = 0;
    stab_errs = 0; w_errs = 0; w_beats = 0;
    s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b00; s_arready = 1;
    s_rvalid = 1; s_rdata = '1; s_rresp = 2'b00; s_rlast = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_read_corrupt();
    test_bresp_error();
    test_stalls();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
